i2c_codec_seq: RTL and testbench

//   Parametrised I2C codec configuration sequencer that drives I2C_Controller over its GO/END/ACK handshake.
//   - Plays a writable command table of {reg[6:0], data[8:0]} words to a fixed 7-bit device address.
//   - Retries a NACKed or timed-out transfer; reports done/error status.
//   - After boot, accepts single runtime register writes (e.g. volume changes).
//   - Runs on the slow I2C clock domain, between system control logic and the I2C bit engine.

---
 rtl/i2c_codec_seq.sv | 184 ++++++++++++++++++
 tb/tb_i2c_codec_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_codec_seq.sv
// rtl/i2c_codec_seq.sv - I2C codec configuration sequencer driving an I2C bit engine over GO/END/ACK
module i2c_codec_seq #(
  parameter int         DEPTH      = 16,
  parameter int         NUM_CMD    = 9,
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYC    = 4,
  parameter int         TIMEOUT    = 255,
  parameter int         AUTO_START = 1,
  localparam int        AW         = $clog2(DEPTH)
) (
  input  logic          clk_i2c,
  input  logic          reset_n,
  input  logic          start,
  input  logic          tbl_we,
  input  logic [AW-1:0] tbl_addr,
  input  logic [15:0]   tbl_wdata,
  input  logic          req_valid,
  input  logic [15:0]   req_data,
  output logic          req_ready,
  output logic [23:0]   i2c_data,
  output logic          i2c_go,
  input  logic          i2c_end,
  input  logic [2:0]    i2c_ack,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] cmd_index
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_END = 3'd2;
  localparam logic [2:0] S_CHECK    = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_READY    = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  // Boot-time codec register image, {reg[6:0], data[8:0]}
  function automatic logic [15:0] dflt_entry(input int idx);
    case (idx)
      0:       dflt_entry = 16'h1E00;  // 0F:000 reset
      1:       dflt_entry = 16'h0C00;  // 06:000 power down control
      2:       dflt_entry = 16'h1002;  // 08:002 sampling control
      3:       dflt_entry = 16'h0479;  // 02:079 left headphone out
      4:       dflt_entry = 16'h0679;  // 03:079 right headphone out
      5:       dflt_entry = 16'h0E01;  // 07:001 digital audio format
      6:       dflt_entry = 16'h1201;  // 09:001 active
      7:       dflt_entry = 16'h0814;  // 04:014 analogue path
      8:       dflt_entry = 16'h0A06;  // 05:006 digital path
      default: dflt_entry = 16'h0000;
    endcase
  endfunction

  logic [15:0] tbl [DEPTH];
  logic [2:0]  state;
  logic [15:0] to_cnt;
  logic [15:0] gap_cnt;
  logic [3:0]  retry_cnt;
  logic        fail;
  logic        rt_mode;
  logic [15:0] req_hold;

  // Command table: reloads defaults on reset, accepts writes in any state
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= dflt_entry(i);
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  // Sequencer: issue, wait for completion or timeout, retry or advance, then idle in READY/ERROR
  always_ff @(posedge clk_i2c or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      i2c_go    <= 1'b0;
      i2c_data  <= 24'h0;
      done      <= 1'b0;
      cmd_index <= '0;
      retry_cnt <= 4'd0;
      to_cnt    <= 16'd0;
      gap_cnt   <= 16'd0;
      fail      <= 1'b0;
      rt_mode   <= 1'b0;
      req_hold  <= 16'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (AUTO_START != 0 || start) begin
            cmd_index <= '0;
            retry_cnt <= 4'd0;
            rt_mode   <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          i2c_data <= {DEV_ADDR, 1'b0, rt_mode ? req_hold : tbl[cmd_index]};
          i2c_go   <= 1'b1;
          to_cnt   <= 16'd0;
          state    <= S_WAIT_END;
        end
        S_WAIT_END: begin
          to_cnt <= to_cnt + 16'd1;
          if (i2c_end) begin
            fail   <= |i2c_ack;
            i2c_go <= 1'b0;
            state  <= S_CHECK;
          end else if (to_cnt + 16'd1 == 16'(TIMEOUT)) begin
            // A silent controller is treated exactly like a NACK
            fail   <= 1'b1;
            i2c_go <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          i2c_go  <= 1'b0;
          gap_cnt <= 16'd0;
          if (fail) begin
            if (retry_cnt != 4'd15) retry_cnt <= retry_cnt + 4'd1;
            // retry_cnt counts earlier failures; this one makes retry_cnt+1
            if (32'(retry_cnt) >= MAX_RETRY) state <= S_ERROR;
            else                             state <= S_GAP;
          end else begin
            retry_cnt <= 4'd0;
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt + 16'd1 >= 16'(GAP_CYC)) begin
            if (fail) begin
              state <= S_ISSUE;
            end else if (rt_mode) begin
              done  <= 1'b1;
              state <= S_READY;
            end else if (32'(cmd_index) + 32'd1 < NUM_CMD) begin
              cmd_index <= cmd_index + 1'b1;
              state     <= S_ISSUE;
            end else begin
              done  <= 1'b1;
              state <= S_READY;
            end
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        S_READY: begin
          if (start) begin
            done      <= 1'b0;
            cmd_index <= '0;
            retry_cnt <= 4'd0;
            rt_mode   <= 1'b0;
            state     <= S_ISSUE;
          end else if (req_valid) begin
            // Runtime write keeps cmd_index and done untouched
            req_hold  <= req_data;
            retry_cnt <= 4'd0;
            rt_mode   <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ERROR: begin
          if (start) begin
            done      <= 1'b0;
            cmd_index <= '0;
            retry_cnt <= 4'd0;
            rt_mode   <= 1'b0;
            state     <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status decoded from state so reset clears it asynchronously
  always_comb begin
    busy      = (state == S_ISSUE) || (state == S_WAIT_END) ||
                (state == S_CHECK) || (state == S_GAP);
    error     = (state == S_ERROR);
    req_ready = (state == S_READY) && !start;
  end

endmodule

// File: tb/tb_i2c_codec_seq.sv
// tb/tb_i2c_codec_seq.sv - directed self-checking bench for i2c_codec_seq
module tb_i2c_codec_seq;

  logic        clk_i2c = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        tbl_we = 1'b0;
  logic [3:0]  tbl_addr = 4'd0;
  logic [15:0] tbl_wdata = 16'h0;
  logic        req_valid = 1'b0;
  logic [15:0] req_data = 16'h0;
  logic        req_ready;
  logic [23:0] i2c_data;
  logic        i2c_go;
  logic        i2c_end = 1'b0;
  logic [2:0]  i2c_ack = 3'b000;
  logic        busy, done, error;
  logic [3:0]  cmd_index;

  int errors = 0;
  int checks = 0;

  // Controller model state
  logic [23:0] xfers[$];
  int          gaps[$];
  int          hi_lens[$];
  logic [23:0] nack_data = 24'h0;
  int          nack_left = 0;
  bit          never_end = 1'b0;
  logic [2:0]  resp_ack = 3'b000;
  logic        go_q = 1'b0;
  int          cnt = 0;
  int          low_cnt = 0;

  i2c_codec_seq dut (
    .clk_i2c   (clk_i2c),
    .reset_n   (reset_n),
    .start     (start),
    .tbl_we    (tbl_we),
    .tbl_addr  (tbl_addr),
    .tbl_wdata (tbl_wdata),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .i2c_data  (i2c_data),
    .i2c_go    (i2c_go),
    .i2c_end   (i2c_end),
    .i2c_ack   (i2c_ack),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .cmd_index (cmd_index)
  );

  always #5 clk_i2c = ~clk_i2c;

  // I2C controller model: ends a transfer 20 cycles after go rises, NACKs chosen data words
  always @(negedge clk_i2c) begin
    if (!reset_n) begin
      i2c_end = 1'b0;
      i2c_ack = 3'b000;
      cnt     = 0;
      go_q    = 1'b0;
    end else begin
      if (i2c_go && !go_q) begin
        xfers.push_back(i2c_data);
        gaps.push_back(low_cnt);
        cnt = 0;
        if (nack_left > 0 && i2c_data == nack_data) begin
          resp_ack  = 3'b010;
          nack_left = nack_left - 1;
        end else begin
          resp_ack = 3'b000;
        end
      end
      if (!i2c_go && go_q) hi_lens.push_back(cnt);
      if (i2c_go) begin
        cnt     = cnt + 1;
        low_cnt = 0;
        if (!never_end && cnt >= 20) begin
          i2c_end = 1'b1;
          i2c_ack = resp_ack;
        end
      end else begin
        i2c_end = 1'b0;
        i2c_ack = 3'b000;
        low_cnt = low_cnt + 1;
      end
      go_q = i2c_go;
    end
  end

  function automatic int count_of(input logic [23:0] v);
    int n = 0;
    foreach (xfers[i]) if (xfers[i] == v) n++;
    return n;
  endfunction

  task automatic clear_log();
    xfers.delete();
    gaps.delete();
    hi_lens.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk_i2c);
    start = 1'b1;
    @(negedge clk_i2c);
    start = 1'b0;
  endtask

  task automatic wait_status(input int max_cyc);
    int n = 0;
    while (!(done || error) && n < max_cyc) begin
      @(negedge clk_i2c);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL wait_status: done=%0b error=%0b after %0d cycles, required done or error", done, error, max_cyc);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i2c);
    checks++;
    if ({i2c_go, busy, done, error, req_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_status: go/busy/done/error/ready=%b required 00000", {i2c_go, busy, done, error, req_ready});
    end
    checks++;
    if (i2c_data !== 24'h0 || cmd_index !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: i2c_data=%h cmd_index=%0d required 000000 and 0", i2c_data, cmd_index);
    end
  endtask

  task automatic test_boot();
    clear_log();
    reset_n = 1'b1;
    wait_status(2000);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL boot_status: done=%b busy=%b error=%b required 1 0 0", done, busy, error);
    end
    checks++;
    if (xfers.size() != 9) begin
      errors++;
      $display("FAIL boot_count: %0d transfers required 9", xfers.size());
    end else begin
      checks++;
      if (xfers[0] !== 24'h341E00 || xfers[8] !== 24'h340A06 || xfers[3] !== 24'h340479) begin
        errors++;
        $display("FAIL boot_data: first=%h mid=%h last=%h required 341e00 340479 340a06", xfers[0], xfers[3], xfers[8]);
      end
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL boot_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_runtime();
    int n = 0;
    clear_log();
    @(negedge clk_i2c);
    req_valid = 1'b1;
    req_data  = 16'h04F0;
    @(negedge clk_i2c);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rt_accept: req_ready=%b busy=%b required 0 1", req_ready, busy);
    end
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk_i2c);
      n++;
    end
    checks++;
    if (xfers.size() != 1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rt_count: %0d transfers ready=%b required 1 transfer ready=1", xfers.size(), req_ready);
    end else begin
      checks++;
      if (xfers[0] !== 24'h3404F0) begin
        errors++;
        $display("FAIL rt_data: %h required 3404f0", xfers[0]);
      end
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rt_done: done=%b required 1", done);
    end
  endtask

  task automatic test_nack_retry();
    int min_gap = 1000;
    clear_log();
    nack_data = 24'h340479;
    nack_left = 2;
    pulse_start();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL nack_done_clear: done=%b required 0", done);
    end
    wait_status(2000);
    checks++;
    if (count_of(24'h340479) != 3 || xfers.size() != 11) begin
      errors++;
      $display("FAIL nack_count: cmd3 x%0d total %0d required 3 and 11", count_of(24'h340479), xfers.size());
    end
    for (int i = 1; i < gaps.size(); i++) if (gaps[i] < min_gap) min_gap = gaps[i];
    checks++;
    if (min_gap < 4) begin
      errors++;
      $display("FAIL nack_gap: min gap %0d required >= 4", min_gap);
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL nack_status: done=%b error=%b required 1 0", done, error);
    end
  endtask

  task automatic test_table_write();
    clear_log();
    @(negedge clk_i2c);
    tbl_we    = 1'b1;
    tbl_addr  = 4'd2;
    tbl_wdata = 16'h1003;
    @(negedge clk_i2c);
    tbl_we = 1'b0;
    pulse_start();
    wait_status(2000);
    checks++;
    if (xfers.size() != 9) begin
      errors++;
      $display("FAIL tbl_count: %0d transfers required 9", xfers.size());
    end else begin
      checks++;
      if (xfers[2] !== 24'h341003) begin
        errors++;
        $display("FAIL tbl_data: third transfer %h required 341003", xfers[2]);
      end
    end
  endtask

  task automatic test_error();
    clear_log();
    nack_data = 24'h340E01;
    nack_left = 100;
    pulse_start();
    wait_status(2000);
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || cmd_index !== 4'd5) begin
      errors++;
      $display("FAIL err_status: error=%b done=%b idx=%0d required 1 0 5", error, done, cmd_index);
    end
    checks++;
    if (count_of(24'h340E01) != 4 || count_of(24'h341201) != 0 || xfers.size() != 9) begin
      errors++;
      $display("FAIL err_count: cmd5 x%0d cmd6 x%0d total %0d required 4 0 9",
               count_of(24'h340E01), count_of(24'h341201), xfers.size());
    end
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL err_flags: busy=%b req_ready=%b required 0 0", busy, req_ready);
    end
    nack_left = 0;
  endtask

  task automatic test_timeout();
    clear_log();
    never_end = 1'b1;
    pulse_start();
    wait_status(3000);
    checks++;
    if (error !== 1'b1 || cmd_index !== 4'd0 || xfers.size() != 4) begin
      errors++;
      $display("FAIL to_status: error=%b idx=%0d transfers=%0d required 1 0 4", error, cmd_index, xfers.size());
    end
    checks++;
    if (hi_lens.size() == 0 || hi_lens[0] != 255) begin
      errors++;
      $display("FAIL to_len: go high %0d cycles required 255", hi_lens.size() == 0 ? -1 : hi_lens[0]);
    end
    never_end = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    pulse_start();
    while (i2c_go !== 1'b1 && n < 100) begin
      @(negedge clk_i2c);
      n++;
    end
    repeat (5) @(negedge clk_i2c);
    checks++;
    if (i2c_go !== 1'b1) begin
      errors++;
      $display("FAIL mid_go: i2c_go=%b required 1 before reset", i2c_go);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({i2c_go, busy, done, error, req_ready} !== 5'b0 || i2c_data !== 24'h0 || cmd_index !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset: go/busy/done/error/ready=%b data=%h idx=%0d required 00000 000000 0",
               {i2c_go, busy, done, error, req_ready}, i2c_data, cmd_index);
    end
    repeat (2) @(negedge clk_i2c);
    clear_log();
    reset_n = 1'b1;
    wait_status(2000);
    checks++;
    if (xfers.size() != 9 || done !== 1'b1) begin
      errors++;
      $display("FAIL mid_reboot: %0d transfers done=%b required 9 1", xfers.size(), done);
    end else begin
      checks++;
      if (xfers[2] !== 24'h341002) begin
        errors++;
        $display("FAIL mid_table: third transfer %h required 341002", xfers[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_runtime();
    test_nack_retry();
    test_table_write();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
